rv64g_l1_refill_sequencer: RTL and testbench
============================================

// Module: rv64g_l1_refill_sequencer
// PURPOSE
//   Upstream write sequencer for one rv64g_l1 SRAM bank. Accepts a line-fill command
//   (index/way/tag/state) and then 8 x 64-bit refill beats from the TileLink D-channel
//   adapter. Writes the beats into the bank as word 0..7 with full byte enables, then
//   commits tag+state in one tag-write cycle. Requests the bank port through a req/gnt
//   arbiter shared with core accesses.
// PARAMETERS
//   INDEX_W         5   set index width (32 sets)
//   TAG_W           53  tag width
//   WORDS_PER_LINE  8   beats per line; power of 2; word counter is log2(WORDS_PER_LINE) bits
// PORTS
//   clk_i           in   1        clock
//   rst_i           in   1        synchronous reset, active-high
//   fill_valid_i    in   1        fill command valid
//   fill_ready_o    out  1        fill command accepted (IDLE only)
//   fill_index_i    in   INDEX_W  set index of line
//   fill_way_i      in   3        victim way
//   fill_tag_i      in   TAG_W    tag to install
//   fill_state_i    in   2        MESI state to install
//   beat_valid_i    in   1        refill beat valid
//   beat_ready_o    out  1        refill beat accepted
//   beat_data_i     in   64       refill beat data; beat k is word k
//   beat_denied_i   in   1        TileLink denied/corrupt flag for this beat
//   bank_req_o      out  1        bank access request
//   bank_gnt_i      in   1        bank grant; write fires when bank_req_o && bank_gnt_i
//   bank_we_o       out  1        data write enable
//   bank_tag_we_o   out  1        tag/state write enable
//   bank_index_o    out  INDEX_W  bank set index
//   bank_word_o     out  3        bank word select
//   bank_way_o      out  3        bank way select
//   bank_be_o       out  8        byte enables (8'hFF on data writes)
//   bank_wdata_o    out  64       write data
//   bank_tag_o      out  TAG_W    tag to write
//   bank_state_o    out  2        state to write
//   busy_o          out  1        not IDLE
//   done_o          out  1        1-cycle pulse, line committed
//   done_err_o      out  1        valid with done_o; 1 if any beat was denied
// BEHAVIOUR
// - Reset: state IDLE; word_cnt=0; beat buffer empty; err=0. All outputs 0 except
//   fill_ready_o=1.
// - FSM IDLE->FILL->COMMIT->IDLE:
//   - IDLE: fill_ready_o=1. On fill_valid_i, capture index/way/tag/state, clear err and
//     word_cnt, go FILL. No bank request in IDLE.
//   - FILL: holds a 1-entry beat buffer.
//     - beat_ready_o = !buf_valid || wr_fire. This is a combinational path from bank_gnt_i
//       and allows 1 beat/cycle under continuous grant.
//     - Accepted beat is loaded into the buffer on the next edge; its denied bit ORs into err.
//     - bank_req_o = buf_valid with bank_we_o=1, bank_tag_we_o=0, bank_be_o=8'hFF,
//       bank_word_o=word_cnt, bank_wdata_o=buffer.
//     - wr_fire: word_cnt++, buffer cleared unless a new beat loads the same cycle.
//     - wr_fire on word WORDS_PER_LINE-1: go COMMIT. No further beats accepted
//       (beat_ready_o=0 from that edge).
//   - COMMIT: bank_req_o=1, bank_we_o=0, bank_tag_we_o=1, bank_tag_o=captured tag.
//     - bank_state_o = err ? MESI_N : captured state.
//     - On grant: done_o=1 and done_err_o=err on the following cycle; state IDLE.
// - bank_index_o/bank_way_o always show the captured command.
// - bank_we_o and bank_tag_we_o are 0 whenever bank_req_o=0.
// - bank_req_o is never withdrawn once raised until granted; payload is stable while
//   waiting for grant.
// - Denied beats are still written; the line is committed Invalid, so the bank never holds
//   a valid line with corrupt data.
// - beat_ready_o=0 outside FILL; beats presented in IDLE/COMMIT are stalled, not dropped.
// - fill_ready_o=0 outside IDLE; a new command is accepted the cycle after done_o at
//   earliest.
// - Latency, continuous beats and grant: command at cycle 0, beats at 1..8, data writes at
//   2..9, tag write at 10, done_o at 11.
// - rst_i mid-fill: FSM returns to IDLE next edge. No further bank requests. Partially
//   written words remain but the tag is not committed.
// TESTING
// - Back-to-back: cmd idx=5 way=3 tag=0x1234 state=E, beats 0x100+k, gnt=1 ->
//   writes word k=0x100+k at cycles 2..9; tag write E at 10; done_o at 11, done_err_o=0.
// - Grant stall: gnt=0 for 4 cycles at word 3 -> bank_req_o held, payload stable,
//   beat_ready_o=0 after 1 buffered beat, no beat lost or duplicated.
// - Denied: beat 6 has beat_denied_i=1 -> all 8 words written; COMMIT state=MESI_N;
//   done_err_o=1.
// - Gappy beats: beat_valid_i every 3rd cycle -> exactly 8 writes in order 0..7, one tag
//   write.
// - Reset after word 4 -> next cycle bank_req_o=0, busy_o=0, fill_ready_o=1, no tag write;
//   a new fill then completes normally.
// - Command in flight: fill_valid_i held during FILL -> fill_ready_o=0 until the cycle
//   after done_o, then accepted.

Source files
------------

// File: rtl/rv64g_l1_refill_sequencer.sv
// Refill write sequencer for one L1 SRAM bank: takes a fill command plus WORDS_PER_LINE beats,
// writes the data words through a req/gnt bank port, then commits tag+state in one tag-write cycle.
module rv64g_l1_refill_sequencer #(
  parameter int INDEX_W        = 5,
  parameter int TAG_W          = 53,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               fill_valid_i,
  output logic               fill_ready_o,
  input  logic [INDEX_W-1:0] fill_index_i,
  input  logic [2:0]         fill_way_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic [1:0]         fill_state_i,
  input  logic               beat_valid_i,
  output logic               beat_ready_o,
  input  logic [63:0]        beat_data_i,
  input  logic               beat_denied_i,
  output logic               bank_req_o,
  input  logic               bank_gnt_i,
  output logic               bank_we_o,
  output logic               bank_tag_we_o,
  output logic [INDEX_W-1:0] bank_index_o,
  output logic [2:0]         bank_word_o,
  output logic [2:0]         bank_way_o,
  output logic [7:0]         bank_be_o,
  output logic [63:0]        bank_wdata_o,
  output logic [TAG_W-1:0]   bank_tag_o,
  output logic [1:0]         bank_state_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               done_err_o
);
  localparam int CNT_W = $clog2(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [1:0] MESI_N = 2'b00;

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q;
  logic               buf_vld_q;
  logic [63:0]        buf_dat_q;
  logic               err_q;
  logic [INDEX_W-1:0] index_q;
  logic [2:0]         way_q;
  logic [TAG_W-1:0]   tag_q;
  logic [1:0]         mstate_q;
  logic               done_q, done_err_q;

  logic fill_fire, beat_fire, wr_fire, tag_fire, last_word;

  assign wr_fire   = (state_q == FILL) && buf_vld_q && bank_gnt_i;
  assign tag_fire  = (state_q == COMMIT) && bank_gnt_i;
  assign last_word = (word_cnt_q == LAST_WORD);
  assign fill_fire = fill_valid_i && fill_ready_o;
  assign beat_fire = beat_valid_i && beat_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_fire) state_d = FILL;
      FILL:    if (wr_fire && last_word) state_d = COMMIT;
      COMMIT:  if (bank_gnt_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done_q blocks fill_ready so a new command lands no earlier than the cycle after done_o.
  always_comb begin
    fill_ready_o  = 1'b0;
    beat_ready_o  = 1'b0;
    bank_req_o    = 1'b0;
    bank_we_o     = 1'b0;
    bank_tag_we_o = 1'b0;
    bank_be_o     = 8'h00;
    case (state_q)
      IDLE: fill_ready_o = !done_q;
      FILL: begin
        // The buffered beat is always word word_cnt_q, so a full buffer on the last word means
        // every beat of the line has already been taken.
        beat_ready_o = !buf_vld_q || (wr_fire && !last_word);
        bank_req_o   = buf_vld_q;
        bank_we_o    = buf_vld_q;
        bank_be_o    = buf_vld_q ? 8'hFF : 8'h00;
      end
      COMMIT: begin
        bank_req_o    = 1'b1;
        bank_tag_we_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_q != IDLE);
  assign bank_index_o = index_q;
  assign bank_way_o   = way_q;
  assign bank_word_o  = 3'(word_cnt_q);
  assign bank_wdata_o = buf_dat_q;
  assign bank_tag_o   = tag_q;
  assign bank_state_o = err_q ? MESI_N : mstate_q;
  assign done_o       = done_q;
  assign done_err_o   = done_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_cnt_q <= '0;
      buf_vld_q  <= 1'b0;
      buf_dat_q  <= '0;
      err_q      <= 1'b0;
      index_q    <= '0;
      way_q      <= '0;
      tag_q      <= '0;
      mstate_q   <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      done_q     <= tag_fire;
      done_err_q <= tag_fire && err_q;
      if (fill_fire) begin
        index_q    <= fill_index_i;
        way_q      <= fill_way_i;
        tag_q      <= fill_tag_i;
        mstate_q   <= fill_state_i;
        err_q      <= 1'b0;
        word_cnt_q <= '0;
        buf_vld_q  <= 1'b0;
      end
      if (wr_fire) word_cnt_q <= word_cnt_q + CNT_W'(1);
      if (beat_fire) begin
        buf_vld_q <= 1'b1;
        buf_dat_q <= beat_data_i;
        err_q     <= err_q || beat_denied_i;
      end else if (wr_fire) begin
        buf_vld_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rv64g_l1_refill_sequencer.sv
// Directed bench for the refill sequencer: latency, grant stalls, denied beats, gappy beats,
// mid-fill reset and command back-pressure.
module tb_rv64g_l1_refill_sequencer;
  localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fill_valid = 1'b0;
  logic        fill_ready;
  logic [4:0]  fill_index = '0;
  logic [2:0]  fill_way = '0;
  logic [52:0] fill_tag = '0;
  logic [1:0]  fill_state = '0;
  logic        beat_valid = 1'b0;
  logic        beat_ready;
  logic [63:0] beat_data = '0;
  logic        beat_denied = 1'b0;
  logic        bank_req, bank_gnt = 1'b1, bank_we, bank_tag_we;
  logic [4:0]  bank_index;
  logic [2:0]  bank_word, bank_way;
  logic [7:0]  bank_be;
  logic [63:0] bank_wdata;
  logic [52:0] bank_tag;
  logic [1:0]  bank_state;
  logic        busy, done, done_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv64g_l1_refill_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .fill_valid_i(fill_valid), .fill_ready_o(fill_ready), .fill_index_i(fill_index),
    .fill_way_i(fill_way), .fill_tag_i(fill_tag), .fill_state_i(fill_state),
    .beat_valid_i(beat_valid), .beat_ready_o(beat_ready), .beat_data_i(beat_data),
    .beat_denied_i(beat_denied),
    .bank_req_o(bank_req), .bank_gnt_i(bank_gnt), .bank_we_o(bank_we), .bank_tag_we_o(bank_tag_we),
    .bank_index_o(bank_index), .bank_word_o(bank_word), .bank_way_o(bank_way), .bank_be_o(bank_be),
    .bank_wdata_o(bank_wdata), .bank_tag_o(bank_tag), .bank_state_o(bank_state),
    .busy_o(busy), .done_o(done), .done_err_o(done_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One line fill. Cycle 0 presents the command; beats start at cycle 1, one every `gap` cycles.
  // stall_word/stall_len withhold grant on that data word; abort_word>=0 resets while that word writes.
  task automatic run_fill(input logic [4:0] idx, input logic [2:0] way, input logic [52:0] tag,
                          input logic [1:0] st, input logic [63:0] base, input logic [7:0] deny,
                          input int gap, input int stall_word, input int stall_len,
                          input bit hold_cmd, input int abort_word, input bit chk_lat);
    int  sent = 0, wr_cnt = 0, tag_cnt = 0, stall_left = stall_len;
    bit  pend = 0, cmd_acc = 0, done_seen = 0, stalled = 0, prev_stall = 0, aborted = 0;
    bit  exp_err = |deny;
    logic [63:0] prev_data = '0;
    logic [2:0]  prev_word = '0;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      @(posedge clk); #1;
      fill_valid = hold_cmd ? 1'b1 : !cmd_acc;
      fill_index = idx; fill_way = way; fill_tag = tag; fill_state = st;
      if (!pend && sent < 8 && c >= 1 && ((c - 1) % gap) == 0) pend = 1;
      beat_valid  = pend;
      beat_data   = pend ? base + 64'(sent) : 64'h0;
      beat_denied = pend ? deny[sent[2:0]] : 1'b0;
      stalled = stall_left > 0 && bank_req && bank_we && (bank_word == stall_word[2:0]);
      if (stalled) stall_left--;
      bank_gnt = !stalled;
      rst = (abort_word >= 0) && bank_req && bank_we && (bank_word == abort_word[2:0]);
      @(negedge clk);
      if (c == 0) chk("cmd_ready_idle", 64'(fill_ready), 64'd1);
      else        chk("cmd_ready_busy", 64'(fill_ready), 64'd0);
      if (fill_valid && fill_ready) cmd_acc = 1;
      if (beat_valid && beat_ready) begin pend = 0; sent++; end
      if (bank_tag_we) chk("beat_ready_commit", 64'(beat_ready), 64'd0);
      if (stalled) chk("stall_beat_ready", 64'(beat_ready), 64'd0);
      if (prev_stall) begin
        chk("stall_req_held", 64'(bank_req), 64'd1);
        chk("stall_word_stable", 64'(bank_word), 64'(prev_word));
        chk("stall_data_stable", bank_wdata, prev_data);
      end
      prev_stall = stalled; prev_word = bank_word; prev_data = bank_wdata;
      if (bank_req && bank_gnt && bank_we) begin
        chk("wr_word", 64'(bank_word), 64'(wr_cnt));
        chk("wr_data", bank_wdata, base + 64'(wr_cnt));
        chk("wr_be", 64'(bank_be), 64'hFF);
        chk("wr_index", 64'(bank_index), 64'(idx));
        chk("wr_way", 64'(bank_way), 64'(way));
        if (chk_lat && wr_cnt == 0) chk("lat_first_wr", 64'(c), 64'd2);
        if (chk_lat && wr_cnt == 7) chk("lat_last_wr", 64'(c), 64'd9);
        wr_cnt++;
      end
      if (bank_req && bank_gnt && bank_tag_we) begin
        chk("tag_value", 64'(bank_tag), 64'(tag));
        chk("tag_state", 64'(bank_state), 64'(exp_err ? ST_I : st));
        chk("tag_we_only", 64'(bank_we), 64'd0);
        chk("tag_after_8_words", 64'(wr_cnt), 64'd8);
        if (chk_lat) chk("lat_tag_wr", 64'(c), 64'd10);
        tag_cnt++;
      end
      if (done) begin
        chk("done_err", 64'(done_err), 64'(exp_err));
        chk("one_tag_write", 64'(tag_cnt), 64'd1);
        if (chk_lat) chk("lat_done", 64'(c), 64'd11);
        done_seen = 1;
      end
      if (rst) begin aborted = 1; break; end
    end
    if (aborted) begin
      @(posedge clk); #1;
      rst = 0; fill_valid = 0; bank_gnt = 1;
      @(negedge clk);
      chk("abort_req", 64'(bank_req), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_fill_ready", 64'(fill_ready), 64'd1);
      chk("abort_beat_ready", 64'(beat_ready), 64'd0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("abort_no_tag", 64'(bank_req || bank_tag_we), 64'd0);
      end
      beat_valid = 0;
    end else begin
      chk("done_seen", 64'(done_seen), 64'd1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_fill_ready", 64'(fill_ready), 64'd1);
    chk("rst_beat_ready", 64'(beat_ready), 64'd0);
    chk("rst_req", 64'(bank_req), 64'd0);
    chk("rst_we", 64'(bank_we || bank_tag_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done || done_err), 64'd0);
    chk("rst_bank_bus", 64'(bank_index) | 64'(bank_word) | 64'(bank_way) | 64'(bank_be)
        | bank_wdata | 64'(bank_tag) | 64'(bank_state), 64'd0);

    run_fill(5'd5, 3'd3, 53'h1234,  ST_E, 64'h100, 8'h00, 1, -1, 0, 0, -1, 1);
    run_fill(5'd7, 3'd1, 53'hABCDE, ST_S, 64'h200, 8'h00, 1,  3, 4, 0, -1, 0);
    run_fill(5'd2, 3'd6, 53'h55,    ST_M, 64'h300, 8'h40, 1, -1, 0, 0, -1, 0);
    run_fill(5'd9, 3'd0, 53'h777,   ST_E, 64'h400, 8'h00, 3, -1, 0, 0, -1, 0);
    run_fill(5'd4, 3'd2, 53'h99,    ST_E, 64'h500, 8'h00, 1, -1, 0, 0,  4, 0);
    run_fill(5'd4, 3'd2, 53'h99,    ST_E, 64'h600, 8'h00, 1, -1, 0, 0, -1, 0);
    run_fill(5'd1, 3'd4, 53'h42,    ST_S, 64'h700, 8'h00, 1, -1, 0, 1, -1, 0);
    run_fill(5'd3, 3'd5, 53'h43,    ST_M, 64'h800, 8'h00, 1, -1, 0, 0, -1, 0);

    @(posedge clk); #1;
    fill_valid = 0; beat_valid = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
